// File: rtl/ri5cy_ahb_pkg.sv
// Shared AHB-Lite types, constants and byte-enable decode for the RI5CY multi-port master.
package ri5cy_ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HsizeByte = 3'b000,
    HsizeHalf = 3'b001,
    HsizeWord = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    HburstSingle = 3'b000,
    HburstIncr   = 3'b001
  } hburst_t;

  // Data access, privileged, non-bufferable, non-cacheable
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef struct packed {
    hsize_t     size;
    logic [1:0] offset;
  } be_dec_t;

  // Map a byte-enable mask to transfer size and low address bits; odd masks fall back to word
  function automatic be_dec_t be_to_hsize(input logic [3:0] be);
    be_dec_t d;
    d.size   = HsizeWord;
    d.offset = 2'b00;
    case (be)
      4'b0011: begin d.size = HsizeHalf; d.offset = 2'b00; end
      4'b1100: begin d.size = HsizeHalf; d.offset = 2'b10; end
      4'b0001: begin d.size = HsizeByte; d.offset = 2'b00; end
      4'b0010: begin d.size = HsizeByte; d.offset = 2'b01; end
      4'b0100: begin d.size = HsizeByte; d.offset = 2'b10; end
      4'b1000: begin d.size = HsizeByte; d.offset = 2'b11; end
      default: begin d.size = HsizeWord; d.offset = 2'b00; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ri5cy_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, advances past it.
module ri5cy_rr_arbiter #(
  parameter int unsigned N_PORTS = 2,
  localparam int unsigned IdxW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_PORTS-1:0] req,
  input  logic               advance,
  output logic [N_PORTS-1:0] gnt,
  output logic [IdxW-1:0]    idx
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] k;
  logic            found;

  // Rotating priority search starting at the pointer
  always_comb begin
    gnt   = '0;
    idx   = '0;
    k     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      k = IdxW'((32'(ptr_q) + i) % N_PORTS);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

  // Pointer moves one past the winner only when the grant is actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = IdxW'((32'(idx) + 1) % N_PORTS);
    end
  end

  // Pointer register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ri5cy_ahb_mport.sv
// Multi-port RI5CY-style request/grant to AHB-Lite master bridge with round-robin arbitration.
// Optional per-port error output enabled by defining RI5CY_AHB_ERR_EN.
module ri5cy_ahb_mport
  import ri5cy_ahb_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [N_PORTS-1:0]                  req_i,
  input  logic [N_PORTS-1:0]                  we_i,
  input  logic [N_PORTS*4-1:0]                be_i,
  input  logic [N_PORTS*AHB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_PORTS*AHB_DATA_WIDTH-1:0]   wdata_i,
  output logic [N_PORTS-1:0]                  gnt_o,
  output logic [N_PORTS-1:0]                  rvalid_o,
  output logic [AHB_DATA_WIDTH-1:0]           rdata_o,
`ifdef RI5CY_AHB_ERR_EN
  output logic [N_PORTS-1:0]                  err_o,
`endif
  output logic                                hsel_o,
  output logic [AHB_ADDR_WIDTH-1:0]           haddr_o,
  output logic [AHB_DATA_WIDTH-1:0]           hwdata_o,
  output logic                                hwrite_o,
  output logic [2:0]                          hsize_o,
  output logic [2:0]                          hburst_o,
  output logic [3:0]                          hprot_o,
  output logic [1:0]                          htrans_o,
  output logic                                hmastlock_o,
  output logic                                hready_o,
  input  logic [AHB_DATA_WIDTH-1:0]           hrdata_i,
  input  logic                                hreadyout_i,
  input  logic                                hresp_i
);

  localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]        arb_gnt;
  logic [IdxW-1:0]           arb_idx;
  logic                      grant_en, err_block, dp_done;
  logic [3:0]                sel_be;
  logic [AHB_ADDR_WIDTH-1:0] sel_addr;
  logic [AHB_DATA_WIDTH-1:0] sel_wdata;
  logic                      sel_we;
  be_dec_t                   dec;

  logic                      dp_valid_q, dp_valid_d;
  logic [IdxW-1:0]           dp_owner_q, dp_owner_d;
  logic                      dp_we_q, dp_we_d;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q, hwdata_d;

  ri5cy_rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_i),
    .advance (grant_en),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  // An error response blocks grants for both of its cycles
  assign err_block = dp_valid_q & hresp_i;
  assign grant_en  = rstn & hreadyout_i & ~err_block & (|req_i);
  assign dp_done   = rstn & dp_valid_q & hreadyout_i;
  assign gnt_o     = arb_gnt & {N_PORTS{grant_en}};

  // Mux the prospective winner's request fields onto the address phase
  always_comb begin
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (arb_idx == IdxW'(i)) begin
        sel_be    = be_i[i*4 +: 4];
        sel_addr  = addr_i[i*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
        sel_wdata = wdata_i[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
        sel_we    = we_i[i];
      end
    end
  end

  assign dec         = be_to_hsize(sel_be);
  assign haddr_o     = {sel_addr[AHB_ADDR_WIDTH-1:2], dec.offset};
  assign hsize_o     = dec.size;
  assign hwrite_o    = grant_en & sel_we;
  assign htrans_o    = grant_en ? HtransNonseq : HtransIdle;
  assign hburst_o    = HburstSingle;
  assign hprot_o     = HPROT_DEFAULT;
  assign hmastlock_o = 1'b0;
  assign hsel_o      = 1'b1;
  assign hready_o    = hreadyout_i;
  assign hwdata_o    = hwdata_q;
  assign rdata_o     = (dp_done && !dp_we_q) ? hrdata_i : '0;

  // Response strobe goes to the owner of the completing data phase
  always_comb begin
    rvalid_o = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      rvalid_o[i] = dp_done & (dp_owner_q == IdxW'(i));
    end
  end

`ifdef RI5CY_AHB_ERR_EN
  assign err_o = rvalid_o & {N_PORTS{hresp_i}};
`endif

  // Data phase advances only when the slave is ready; wait states hold everything
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    dp_we_d    = dp_we_q;
    hwdata_d   = hwdata_q;
    if (hreadyout_i) begin
      dp_valid_d = grant_en;
      if (grant_en) begin
        dp_owner_d = arb_idx;
        dp_we_d    = sel_we;
        hwdata_d   = sel_wdata;
      end
    end
  end

  // Data-phase state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dp_valid_q <= 1'b0;
      dp_owner_q <= '0;
      dp_we_q    <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
      dp_we_q    <= dp_we_d;
      hwdata_q   <= hwdata_d;
    end
  end

endmodule
